vlc_manchester_rx: RTL and testbench

Oversampling Manchester decoder for the VLC receive path. It takes the raw photodiode comparator level, sampled at SPB clocks per bit, and recovers bit timing from mid-bit transitions. It locks on an alternating preamble, then emits one decoded bit per bit period as a single-cycle pulse. Its outputs drive the serial-to-parallel byte accumulator directly downstream.

---
 rtl/vlc_manchester_rx_pkg.sv | 26 ++
 rtl/vlc_manchester_rx_if.sv | 25 ++
 rtl/vlc_edge_sync.sv | 28 ++
 rtl/vlc_manchester_rx.sv | 135 +++++++++++++
 tb/tb_vlc_manchester_rx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vlc_manchester_rx_pkg.sv
// Shared VLC definitions: receiver state encoding, mid-bit window derivation
// and the Manchester polarity convention used by both encoder and decoder.
package vlc_manchester_rx_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StSync,
    StLocked
  } vlc_state_e;

  // Level after a mid-bit transition that encodes a logic 1 (rising mid-bit = 1).
  localparam logic MidRiseBit = 1'b1;

  function automatic int unsigned win_q(input int unsigned spb);
    return spb / 4;
  endfunction

  function automatic int unsigned win_early(input int unsigned spb);
    return spb - win_q(spb);
  endfunction

  function automatic int unsigned win_late(input int unsigned spb);
    return spb + win_q(spb);
  endfunction

endpackage

// File: rtl/vlc_manchester_rx_if.sv
// Receive-side bundle between the comparator input, the decoder and the
// downstream byte accumulator.
interface vlc_manchester_rx_if;
  logic rx_in;
  logic bit_out;
  logic bit_valid;
  logic locked;
  logic err;

  modport master (
    output rx_in,
    input  bit_out,
    input  bit_valid,
    input  locked,
    input  err
  );

  modport slave (
    input  rx_in,
    output bit_out,
    output bit_valid,
    output locked,
    output err
  );
endinterface

// File: rtl/vlc_edge_sync.sv
// Two-flop synchronizer for the asynchronous comparator level plus a
// previous-sample register for transition detection.
module vlc_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic edge_o,
  output logic level_o
);

  logic s1_q, s2_q, prv_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      prv_q <= 1'b0;
    end else begin
      s1_q  <= rx_i;
      s2_q  <= s1_q;
      prv_q <= s2_q;
    end
  end

  assign edge_o  = s2_q ^ prv_q;
  assign level_o = s2_q;

endmodule

// File: rtl/vlc_manchester_rx.sv
// Oversampling Manchester decoder: locks on an alternating preamble, then
// emits one registered bit pulse per mid-bit transition inside the window.
module vlc_manchester_rx
  import vlc_manchester_rx_pkg::*;
#(
  parameter int unsigned SPB      = 16,
  parameter int unsigned PRE_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  vlc_manchester_rx_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(2 * SPB);
  localparam int unsigned PreW = $clog2(PRE_BITS + 1);

  localparam logic [CntW-1:0] CntMax   = CntW'(2 * SPB - 1);
  localparam logic [CntW-1:0] WinQ     = CntW'(win_q(SPB));
  localparam logic [CntW-1:0] WinEarly = CntW'(win_early(SPB));
  localparam logic [CntW-1:0] WinLate  = CntW'(win_late(SPB));
  localparam logic [PreW-1:0] PreLock  = PreW'(PRE_BITS);
  // The anchoring edge cycle is sample 0; the registered count is already one
  // sample past it, so cnt_q equals the true edge spacing when the next edge lands.
  localparam logic [CntW-1:0] CntRestart = CntW'(1);

  logic rx_edge, rx_level;

  vlc_edge_sync u_edge_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .rx_i    (bus_io.rx_in),
    .edge_o  (rx_edge),
    .level_o (rx_level)
  );

  vlc_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            bflag_q, bflag_d;
  logic            bit_out_q, bit_out_d;
  logic            bit_valid_q, bit_valid_d;
  logic            err_q, err_d;

  logic in_win, in_bnd, timeout;

  assign in_win  = (cnt_q >= WinEarly) && (cnt_q <= WinLate);
  assign in_bnd  = (cnt_q >= WinQ) && (cnt_q < WinEarly);
  assign timeout = cnt_q > WinLate;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    pre_d       = pre_q;
    bflag_d     = bflag_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (rx_edge) begin
          state_d = StSync;
          cnt_d   = CntRestart;
          pre_d   = '0;
        end
      end

      StSync: begin
        if (rx_edge) begin
          cnt_d = CntRestart;
          if (in_win) begin
            pre_d = pre_q + 1'b1;
            if (pre_q + 1'b1 == PreLock) begin
              state_d = StLocked;
              bflag_d = 1'b0;
            end
          end else begin
            pre_d = '0;
          end
        end else if (timeout) begin
          state_d = StHunt;
        end
      end

      StLocked: begin
        if (rx_edge) begin
          if (in_win) begin
            bit_out_d   = (rx_level == MidRiseBit);
            bit_valid_d = 1'b1;
            cnt_d       = CntRestart;
            bflag_d     = 1'b0;
          end else if (in_bnd && !bflag_q) begin
            bflag_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StHunt;
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      pre_q       <= '0;
      bflag_q     <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      bflag_q     <= bflag_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.bit_out   = bit_out_q;
  assign bus_io.bit_valid = bit_valid_q;
  assign bus_io.err       = err_q;
  assign bus_io.locked    = (state_q == StLocked);

endmodule

// File: tb/tb_vlc_manchester_rx.sv
// Bench for vlc_manchester_rx: builds a sample-level rx waveform, predicts the
// outputs from edge timestamps, and compares every cycle.
module tb_vlc_manchester_rx;

  localparam int SPB      = 16;
  localparam int PRE_BITS = 8;
  localparam int Q        = SPB / 4;
  localparam int EARLY    = SPB - Q;
  localparam int LATE     = SPB + Q;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vlc_manchester_rx_if bus ();

  vlc_manchester_rx #(
    .SPB      (SPB),
    .PRE_BITS (PRE_BITS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  bit stim_rx[$];
  bit stim_rst[$];
  bit e_valid[];
  bit e_bit[];
  bit e_err[];
  bit e_lock[];

  int n_tests = 0;
  int n_fail  = 0;
  int dut_pulses = 0;
  int exp_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input bit v, input int n, input bit r = 1'b0);
    for (int i = 0; i < n; i++) begin
      stim_rx.push_back(v);
      stim_rst.push_back(r);
    end
  endtask

  // Manchester bit: first half is the complement, second half is the bit value.
  task automatic add_bit(input bit b, input int h1, input int h2);
    add(!b, h1);
    add(b, h2);
  endtask

  task automatic add_pre(input int n);
    for (int i = 0; i < n; i++) add_bit((i % 2) == 0, SPB / 2, SPB / 2);
  endtask

  task automatic add_rand_bits(input int n, input int hmin, input int hmax);
    for (int i = 0; i < n; i++)
      add_bit(1'($urandom), int'($urandom_range(hmax, hmin)), int'($urandom_range(hmax, hmin)));
  endtask

  // Reference: walk the waveform sample by sample using edge timestamps.
  // mode 0 = hunting, 1 = counting preamble spacings, 2 = locked.
  task automatic run_model();
    int n = stim_rx.size();
    int mode = 0, anchor = 0, pre = 0, gap = 0;
    bit bseen = 0, prev = 0, held = 0, lvl, ed, rst_near;
    e_valid = new[n + 2];
    e_bit   = new[n + 2];
    e_err   = new[n + 2];
    e_lock  = new[n + 2];
    for (int t = 0; t < n; t++) begin
      rst_near = stim_rst[t] || (t + 1 < n && stim_rst[t + 1]) || (t + 2 < n && stim_rst[t + 2]);
      if (rst_near) begin
        mode = 0;
        held = 0;
        prev = 0;
        e_bit[t + 2]  = 0;
        e_lock[t + 2] = 0;
        continue;
      end
      lvl  = stim_rx[t];
      ed   = (lvl != prev);
      prev = lvl;
      gap  = t - anchor;
      if (mode == 0) begin
        if (ed) begin
          mode = 1; anchor = t; pre = 0;
        end
      end else if (mode == 1) begin
        if (ed) begin
          anchor = t;
          if (gap >= EARLY && gap <= LATE) begin
            pre++;
            if (pre == PRE_BITS) begin
              mode = 2; bseen = 0;
            end
          end else begin
            pre = 0;
          end
        end else if (gap > LATE) begin
          mode = 0;
        end
      end else begin
        if (ed) begin
          if (gap >= EARLY && gap <= LATE) begin
            held = lvl; e_valid[t + 2] = 1; anchor = t; bseen = 0; exp_pulses++;
          end else if (gap >= Q && gap < EARLY && !bseen) begin
            bseen = 1;
          end else begin
            e_err[t + 2] = 1; mode = 0;
          end
        end else if (gap > LATE) begin
          e_err[t + 2] = 1; mode = 0;
        end
      end
      e_bit[t + 2]  = held;
      e_lock[t + 2] = (mode == 2);
    end
  endtask

  task automatic check_cycle(input int o);
    check_eq($sformatf("bit_valid@%0d", o), 32'(bus.bit_valid), 32'(e_valid[o]));
    check_eq($sformatf("bit_out@%0d", o), 32'(bus.bit_out), 32'(e_bit[o]));
    check_eq($sformatf("err@%0d", o), 32'(bus.err), 32'(e_err[o]));
    check_eq($sformatf("locked@%0d", o), 32'(bus.locked), 32'(e_lock[o]));
    if (bus.bit_valid === 1'b1) dut_pulses++;
  endtask

  initial begin
    bit b;
    bus.rx_in = 1'b0;

    // Reset held two cycles while rx toggles.
    add(1, 1, 1); add(0, 1, 1); add(1, 1); add(0, 12);

    // Lock and decode a fixed pattern, then hold the line for a timeout.
    add_pre(PRE_BITS + 1);
    add_bit(0, 8, 8); add_bit(1, 8, 8); add_bit(0, 8, 8); add_bit(1, 8, 8);
    add_bit(1, 8, 8); add_bit(0, 8, 8); add_bit(1, 8, 8); add_bit(0, 8, 8);
    add(0, 40);

    // Spacing of 11 while syncing restarts the count; then jittered spacings.
    add_bit(1, 8, 8); add_bit(0, 8, 8); add_bit(1, 8, 8); add_bit(0, 8, 8);
    add_bit(1, 8, 8); add_bit(0, 3, 8);
    add_pre(PRE_BITS + 1);
    add_bit(1'($urandom), 4, 8);
    add_bit(1'($urandom), 12, 8);
    add_bit(1'($urandom), 5, 8);
    add_bit(1'($urandom), 11, 8);
    add_rand_bits(4, 8, 8);
    add(0, 40);

    // Glitch one sample after a mid-bit edge, then relock.
    add_pre(PRE_BITS + 1);
    add_rand_bits(3, 8, 8);
    b = 1'($urandom);
    add(!b, 8); add(b, 1); add(!b, 2); add(b, 5);
    add_rand_bits(3, 8, 8);
    add(0, 40);
    add_pre(PRE_BITS + 1);
    add_rand_bits(6, 8, 8);

    // One-cycle reset mid-frame; data that follows must be ignored.
    b = 1'($urandom);
    add(!b, 8); add(b, 4); add(b, 1, 1); add(b, 3);
    add_rand_bits(6, 8, 8);
    add(0, 40);
    add_pre(PRE_BITS + 1);
    add_rand_bits(8, 8, 8);
    add(0, 40);

    // Random frames with per-half jitter inside the tracking tolerance.
    for (int f = 0; f < 6; f++) begin
      add_pre(PRE_BITS + 1);
      add_rand_bits(int'($urandom_range(20, 10)), 10, 6);
      add(0, 30);
    end

    run_model();

    for (int t = 0; t < stim_rx.size(); t++) begin
      @(negedge clk);
      if (t > 0) check_cycle(t - 1);
      bus.rx_in = stim_rx[t];
      rst       = stim_rst[t];
    end
    @(negedge clk);
    check_cycle(stim_rx.size() - 1);
    check_eq("pulse_total", 32'(dut_pulses), 32'(exp_pulses));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
